// File: rtl/dmem_param.sv
// Parametrised data memory with byte/half/word access, sign/zero extension,
// req/ready handshake, configurable read latency and misalignment detection.
`timescale 1ns/1ps
module dmem_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sext,
    input  logic [31:0]           a,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  rd_valid,
    output logic                  err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = 3;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_word;
    logic [OFF-1:0]          r_off;
    logic [1:0]              r_size;
    logic                    r_sext;

    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [OFF-1:0]          w_off;
    logic                    w_illegal, w_acc, w_rd_acc, w_wr_acc, w_fire;
    logic [NB-1:0]           w_be;
    logic [DATA_WIDTH-1:0]   w_wdata, w_mem_word, w_result;
    logic                    w_unused;

    assign w_idx      = a[ADDR_WIDTH+OFF-1:OFF];
    assign w_off      = a[OFF-1:0];
    assign w_unused   = ^a[31:ADDR_WIDTH+OFF];
    assign w_mem_word = r_mem[w_idx];

    assign ready     = !reset && (r_state == S_IDLE);
    assign w_acc     = req && ready;
    assign w_illegal = (size == 2'b11) || (size == 2'b01 && a[0]) ||
                       (size == 2'b10 && w_off != '0);
    assign w_rd_acc  = w_acc && !w_illegal && !we;
    assign w_wr_acc  = w_acc && !w_illegal && we;

    // Selects the addressed field, right-aligns it and extends to full width.
    function automatic logic [DATA_WIDTH-1:0] f_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [OFF-1:0]        off,
        input logic [1:0]            sz,
        input logic                  sx
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            2'b00:   f_extend = {{(DATA_WIDTH-8){sx & sh[7]}}, sh[7:0]};
            2'b01:   f_extend = {{(DATA_WIDTH-16){sx & sh[15]}}, sh[15:0]};
            default: f_extend = sh;
        endcase
    endfunction

    always_comb begin
        case (size)
            2'b00:   w_be = NB'(1) << w_off;
            2'b01:   w_be = NB'(3) << w_off;
            default: w_be = '1;
        endcase
        w_wdata = wd << {w_off, 3'b000};
    end

    // Single-cycle latency returns straight from the array on the accept edge.
    assign w_result = (READ_LATENCY == 1) ? f_extend(w_mem_word, w_off, size, sext)
                                          : f_extend(r_word, r_off, r_size, r_sext);

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_acc) begin
                    if (READ_LATENCY == 1) begin
                        w_fire = 1'b1;
                    end else begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CW'(READ_LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_word   <= '0;
            r_off    <= '0;
            r_size   <= '0;
            r_sext   <= 1'b0;
            rd       <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            rd_valid <= w_fire;
            err      <= w_acc && w_illegal;
            if (w_fire) rd <= w_result;
            if (w_rd_acc) begin
                r_word <= w_mem_word;
                r_off  <= w_off;
                r_size <= size;
                r_sext <= sext;
            end
        end
    end

    // NOTE: the array has no reset; its contents survive reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_param.sv
// Directed bench for dmem_param: one instance with READ_LATENCY = 1, one with 3.
`timescale 1ns/1ps
module tb_dmem_param;
    logic        clk = 1'b0;
    logic        reset, req1, req3, we, sext;
    logic [1:0]  size;
    logic [31:0] a, wd;
    logic        ready1, rd_valid1, err1, ready3, rd_valid3, err3;
    logic [31:0] rd1, rd3;
    int          checks = 0;
    int          failures = 0;
    int          seen;

    always #5 clk = ~clk;

    dmem_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we), .size(size), .sext(sext),
        .a(a), .wd(wd), .ready(ready1), .rd(rd1), .rd_valid(rd_valid1), .err(err1)
    );

    dmem_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we), .size(size), .sext(sext),
        .a(a), .wd(wd), .ready(ready3), .rd(rd3), .rd_valid(rd_valid3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setup(input logic w, input logic [1:0] s, input logic x,
                         input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        we = w; size = s; sext = x; a = addr; wd = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc1(input logic w, input logic [1:0] s, input logic x,
                        input logic [31:0] addr, input logic [31:0] d);
        setup(w, s, x, addr, d);
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
    endtask

    task automatic acc3(input logic w, input logic [1:0] s, input logic x,
                        input logic [31:0] addr, input logic [31:0] d);
        setup(w, s, x, addr, d);
        req3 = 1'b1;
        tick();
        req3 = 1'b0;
    endtask

    task automatic read1(input string tag, input logic [1:0] s, input logic x,
                         input logic [31:0] addr, input logic [31:0] exp);
        acc1(1'b0, s, x, addr, 32'h0);
        check({tag, "_valid"}, 32'(rd_valid1), 32'd1);
        check(tag, rd1, exp);
    endtask

    task automatic illegal1(input string tag, input logic w, input logic [1:0] s,
                            input logic [31:0] addr, input logic [31:0] rd_exp);
        acc1(w, s, 1'b0, addr, 32'h0);
        check({tag, "_err"}, 32'(err1), 32'd1);
        check({tag, "_novalid"}, 32'(rd_valid1), 32'd0);
        check({tag, "_rdhold"}, rd1, rd_exp);
    endtask

    initial begin
        reset = 1'b1; req1 = 1'b0; req3 = 1'b0; we = 1'b0; sext = 1'b0;
        size = 2'b00; a = '0; wd = '0;
        tick(); tick();
        check("rst_ready1", 32'(ready1), 32'd0);
        check("rst_ready3", 32'(ready3), 32'd0);
        check("rst_rd1", rd1, 32'h0);
        check("rst_valid1", 32'(rd_valid1), 32'd0);
        check("rst_err1", 32'(err1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready1", 32'(ready1), 32'd1);

        // Latency-1 word round trip
        acc1(1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFF_FFFC);
        check("wr_novalid", 32'(rd_valid1), 32'd0);
        read1("rd_word4", 2'b10, 1'b0, 32'h4, 32'hFFFF_FFFC);
        check("rd_word4_ready", 32'(ready1), 32'd1);
        tick();
        check("valid_pulse", 32'(rd_valid1), 32'd0);
        check("rd_hold", rd1, 32'hFFFF_FFFC);

        // Byte lanes with sign/zero extension
        acc1(1'b1, 2'b10, 1'b0, 32'h100, 32'h0000_0000);
        acc1(1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_0085);
        read1("rd_byte_sx", 2'b00, 1'b1, 32'h102, 32'hFFFF_FF85);
        read1("rd_byte_zx", 2'b00, 1'b0, 32'h102, 32'h0000_0085);
        read1("rd_word100", 2'b10, 1'b0, 32'h100, 32'h0085_0000);

        acc1(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
        read1("rd_half_sx", 2'b01, 1'b1, 32'h12, 32'hFFFF_8001);

        // Illegal requests
        illegal1("half_13", 1'b0, 2'b01, 32'h13, 32'hFFFF_8001);
        tick();
        check("err_pulse", 32'(err1), 32'd0);
        illegal1("word_6", 1'b0, 2'b10, 32'h6, 32'hFFFF_8001);
        illegal1("size11", 1'b0, 2'b11, 32'h4, 32'hFFFF_8001);
        illegal1("wr_word_6", 1'b1, 2'b10, 32'h6, 32'hFFFF_8001);
        illegal1("wr_size11", 1'b1, 2'b11, 32'h4, 32'hFFFF_8001);
        read1("mem4_intact", 2'b10, 1'b0, 32'h4, 32'hFFFF_FFFC);
        read1("wrap_404", 2'b10, 1'b0, 32'h404, 32'hFFFF_FFFC);

        // Latency-3 handshake
        acc3(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678);
        acc3(1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D);
        setup(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        req3 = 1'b1;
        tick();
        check("l3_e1_ready", 32'(ready3), 32'd0);
        check("l3_e1_valid", 32'(rd_valid3), 32'd0);
        tick();
        check("l3_e2_ready", 32'(ready3), 32'd0);
        check("l3_e2_valid", 32'(rd_valid3), 32'd0);
        tick();
        check("l3_e3_valid", 32'(rd_valid3), 32'd1);
        check("l3_e3_rd", rd3, 32'h1234_5678);
        check("l3_e3_ready", 32'(ready3), 32'd1);
        @(negedge clk);
        a = 32'h44;
        tick();
        req3 = 1'b0;
        check("l3_b2b_ready", 32'(ready3), 32'd0);
        check("l3_b2b_valid", 32'(rd_valid3), 32'd0);
        tick();
        check("l3_b2b_e2_valid", 32'(rd_valid3), 32'd0);
        tick();
        check("l3_b2b_valid3", 32'(rd_valid3), 32'd1);
        check("l3_b2b_rd", rd3, 32'hCAFE_F00D);
        tick();
        check("l3_idle_valid", 32'(rd_valid3), 32'd0);
        check("l3_idle_ready", 32'(ready3), 32'd1);

        // Reset during a latency-3 read
        acc3(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready3), 32'd0);
        check("abort_rd", rd3, 32'h0);
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rd_valid3) seen++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready_rel", 32'(ready3), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rd_valid3) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_rd_zero", rd3, 32'h0);

        acc3(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        tick();
        tick();
        check("post_abort_valid", 32'(rd_valid3), 32'd1);
        check("post_abort_rd", rd3, 32'h1234_5678);
        read1("post_rst_mem4", 2'b10, 1'b0, 32'h4, 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
